// File: rtl/inst_trace_buffer.sv
// Instruction trace buffer: captures (pc, inst, seq) records from the CPU
// into a first-word-fall-through FIFO and freezes capture once the program
// parks on a self-looping pc for HALT_RUN repeats.
module inst_trace_buffer #(
    parameter int ADDR_W   = 32,
    parameter int INST_W   = 32,
    parameter int DEPTH    = 16,
    parameter int SEQ_W    = 16,
    parameter int HALT_RUN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          pc,
    input  logic [INST_W-1:0]          inst,
    input  logic                       cap_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic                       halted
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int REP_W = $clog2(HALT_RUN+1);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                r_full;
    logic                r_overflow;
    logic [SEQ_W-1:0]    r_seq;
    logic [REP_W-1:0]    r_rep;
    logic [REP_W-1:0]    w_rep_next;
    logic [ADDR_W-1:0]   r_last_pc;
    logic                r_last_vld;
    logic                w_elig;
    logic                w_valid;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop;

    // Storage is data only; validity is tracked by the pointers and count.
    logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0]   r_mem_inst [DEPTH];
    logic [SEQ_W-1:0]    r_mem_seq  [DEPTH];

    assign w_elig     = (r_state == S_RUN) && cap_en;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok  = w_elig && (!r_full || w_pop);
    assign w_drop     = w_elig && r_full && !w_pop;
    assign w_rep_next = (r_last_vld && (pc == r_last_pc)) ? r_rep + 1'b1 : '0;

    // Next-state for the RUN/HALT machine; HALT is only left through reset.
    always_comb begin
        w_state_next = r_state;
        if (w_elig && (w_rep_next == REP_W'(HALT_RUN))) begin
            w_state_next = S_HALT;
        end
    end

    // Occupancy update from the push/pop combination.
    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push_ok && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Control: pointers, occupancy, flags, sequence stamp and repeat tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_seq      <= '0;
            r_rep      <= '0;
            r_last_pc  <= '0;
            r_last_vld <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Stamp advances on dropped records too, so gaps reveal losses.
            if (w_elig) begin
                r_seq      <= r_seq + 1'b1;
                r_rep      <= w_rep_next;
                r_last_pc  <= pc;
                r_last_vld <= 1'b1;
            end
        end
    end

    // Record write into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_pc[r_wr_ptr]   <= pc;
            r_mem_inst[r_wr_ptr] <= inst;
            r_mem_seq[r_wr_ptr]  <= r_seq;
        end
    end

    // Head is forced to zero when empty so the post-reset outputs read 0.
    assign out_valid = w_valid;
    assign out_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign out_inst  = w_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign out_seq   = w_valid ? r_mem_seq[r_rd_ptr]  : '0;
    assign count     = r_count;
    assign full      = r_full;
    assign overflow  = r_overflow;
    assign halted    = (r_state == S_HALT);

endmodule

// File: doc/inst_trace_buffer.md
Name: inst_trace_buffer

Overview:
- Sits directly downstream of single_period_cpu and consumes its per-cycle pc/inst outputs.
- Records each executed (pc, inst) pair, with a sequence stamp, into an on-chip FIFO. A bench or debug port drains the FIFO through a valid/ready handshake.
- Detects program completion (PC self-loop) and freezes capture, so benches can end on a hardware flag instead of a fixed cycle count.

Parameters:
- ADDR_W, 32, pc width; matches `ADDR_LEN in defines.v.
- INST_W, 32, instruction width; matches `INSTR_LEN in defines.v.
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- SEQ_W, 16, sequence stamp width.
- HALT_RUN, 4, number of consecutive repeated pc values that declares a halt; must be at least 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  ADDR_W  pc of the instruction executing this cycle.
- inst  in  INST_W  instruction word executing this cycle.
- cap_en  in  1  capture enable.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_pc  out  ADDR_W  head entry pc.
- out_inst  out  INST_W  head entry instruction.
- out_seq  out  SEQ_W  head entry sequence stamp.
- count  out  clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag: at least one record was dropped.
- halted  out  1  halt has been detected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers, count, seq and repeat counter go to 0.
  - overflow=0, halted=0, last_pc_vld=0.
  - out_valid=0; out_pc, out_inst and out_seq read 0.
  - Reset asserted mid-operation discards all stored entries; no pop handshake completes in that cycle.
- FSM has two states:
  - RUN: the reset state.
  - HALT: entered from RUN; left only by rst.
- Eligible cycle: state==RUN and cap_en=1.
- On each eligible cycle:
  - Push attempt of {pc, inst, seq}.
  - seq increments by 1 and wraps modulo 2^SEQ_W.
  - seq increments even when the record is dropped, so stamp gaps expose drops.
  - seq does not change on non-eligible cycles.
- Repeat detection, on eligible cycles only:
  - rep_next = (last_pc_vld && pc==last_pc) ? rep+1 : 0.
  - last_pc is set to pc and last_pc_vld is set to 1.
  - If rep_next == HALT_RUN, go to HALT; halted=1 from the next cycle.
  - The record that completes the run is still pushed, subject to space.
  - Non-eligible cycles hold rep, last_pc and last_pc_vld unchanged.
- HALT state: no pushes and seq frozen; draining continues normally.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0).
  - out_* always reflect the head entry.
  - A pop occurs when out_valid && out_ready.
  - out_* are don't-care while out_valid=0.
- Full and simultaneous events:
  - Push while full with no pop in the same cycle: the record is dropped and overflow is set to 1 (sticky until rst).
  - Push while full with a pop in the same cycle: the push is accepted; count stays DEPTH and no overflow.
  - Push and pop when not empty: count unchanged.
  - Pop only: count decrements by 1.
  - Push only: count increments by 1.
  - A pop while empty cannot occur because out_valid=0.
  - Pointers wrap modulo DEPTH.
- Latency: a record pushed at edge N is visible on out_* with out_valid=1 after edge N. No same-cycle bypass from pc/inst to out_*.
- count, full, overflow and halted are all registered outputs.

Test Plan:
- Basic capture: reset, then 5 cycles with cap_en=1, pc 0,4,8,12,16 and inst 0x11..0x15, out_ready=0 → count=5, head pc=0, inst=0x11, seq=0. Then out_ready=1 → drains in order with seq 0..4; out_valid falls after the 5th pop.
- Halt: pc sequence 0,4,8,8,8,8,8 with HALT_RUN=4 → the 8 at the 5th repeat-sequence position (rep 1,2,3,4) sets halted on the next cycle. Entries captured: 0,4 and five 8s (7 total). Further cycles add nothing; count stays 7.
- Overflow: DEPTH=16, out_ready=0, 20 eligible cycles → count=16, full=1, overflow=1. Head seq=0 and tail seq=15; after draining 16, the next pushed entry carries seq=20.
- Full with simultaneous pop: fill to 16, then push with out_ready=1 → count stays 16, overflow stays 0, head advances to seq=1.
- cap_en gating: cap_en=0 for 3 cycles with a constant pc between captures → no pushes, seq and rep unchanged, no false halt.
- Reset mid-operation: 8 entries stored, halted=1, overflow=1; assert rst for 1 cycle → count=0, out_valid=0, halted=0, overflow=0. The next capture gets seq=0, and a pc equal to the pre-reset last_pc is not counted as a repeat.
